// File: rtl/mac_acc_ctrl.sv
// Accumulation controller: keeps ADDER_LATENCY interleaved partial sums circulating
// through a pipelined adder, then reduces them to a single dot-product result.
module mac_acc_ctrl #(
    parameter int WIDTH         = 40,
    parameter int ADDER_LATENCY = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_prod,
    input  logic             i_prod_valid,
    input  logic             i_prod_last,
    output logic             o_prod_ready,
    output logic [WIDTH-1:0] o_adder_a,
    output logic [WIDTH-1:0] o_adder_b,
    output logic             o_adder_valid,
    input  logic [WIDTH-1:0] i_adder_val,
    input  logic             i_adder_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_result_valid
);
    localparam int CW = $clog2(ADDER_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COLLECT, S_REDUCE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic [CW-1:0]    infl_q, infl_d;
    logic [WIDTH-1:0] fifo_q [ADDER_LATENCY];
    logic [WIDTH-1:0] fifo_d [ADDER_LATENCY];
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic             accept;
    logic             pop;
    logic             push;
    logic             clear;
    logic [WIDTH-1:0] push_val;
    logic [CW-1:0]    wr_idx;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        infl_d         = infl_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        o_prod_ready   = 1'b0;
        o_adder_a      = '0;
        o_adder_b      = '0;
        o_adder_valid  = 1'b0;
        accept         = 1'b0;
        pop            = 1'b0;
        push           = 1'b0;
        clear          = 1'b0;
        push_val       = '0;

        case (state_q)
            S_IDLE: begin
                o_prod_ready = i_rst_n;
                accept       = i_prod_valid & i_rst_n;
                cnt_d        = '0;
                if (accept) begin
                    o_adder_a     = i_prod;
                    o_adder_valid = 1'b1;
                    state_d       = i_prod_last ? S_COLLECT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                // Issue every cycle so slot k stays aligned with its own returning sum.
                o_prod_ready  = i_rst_n;
                accept        = i_prod_valid & i_rst_n;
                o_adder_valid = 1'b1;
                o_adder_a     = accept ? i_prod : '0;
                o_adder_b     = i_adder_valid ? i_adder_val : '0;
                if (accept && i_prod_last) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                push     = 1'b1;
                push_val = i_adder_valid ? i_adder_val : '0;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(ADDER_LATENCY - 1)) begin
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                pop      = (fcnt_q >= CW'(2));
                push     = i_adder_valid;
                push_val = i_adder_val;
                if (pop) begin
                    o_adder_a     = fifo_q[0];
                    o_adder_b     = fifo_q[1];
                    o_adder_valid = 1'b1;
                end
                infl_d = infl_q + (pop ? CW'(1) : CW'(0)) - (push ? CW'(1) : CW'(0));
                if (fcnt_q == CW'(1) && infl_q == '0) begin
                    result_d       = fifo_q[0];
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                    clear          = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Partial-sum FIFO kept compacted at index 0; a pop removes two, a push appends one.
    always_comb begin
        fifo_d = fifo_q;
        wr_idx = fcnt_q - (pop ? CW'(2) : CW'(0));
        fcnt_d = fcnt_q - (pop ? CW'(2) : CW'(0)) + (push ? CW'(1) : CW'(0));
        if (pop) begin
            for (int i = 0; i < ADDER_LATENCY - 2; i++) begin
                fifo_d[i] = fifo_q[i + 2];
            end
            fifo_d[ADDER_LATENCY - 2] = '0;
            fifo_d[ADDER_LATENCY - 1] = '0;
        end
        for (int i = 0; i < ADDER_LATENCY; i++) begin
            if (push && wr_idx == CW'(i)) begin
                fifo_d[i] = push_val;
            end
        end
        if (clear) begin
            for (int i = 0; i < ADDER_LATENCY; i++) begin
                fifo_d[i] = '0;
            end
            fcnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            fcnt_q         <= '0;
            infl_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            for (int i = 0; i < ADDER_LATENCY; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fcnt_q         <= fcnt_d;
            infl_q         <= (clear ? '0 : infl_d);
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            for (int i = 0; i < ADDER_LATENCY; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;

endmodule
